// File: rtl/priority_encoder_16_4.sv
// Registered 16-to-4 priority encoder: sticky pending set, lowest index first,
// codes retired one at a time through a valid/ready handshake.
module priority_encoder_16_4 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    input  logic        en,
    output logic [3:0]  y,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  y_next;
    logic [15:0] set;
    logic [15:0] clr;
    logic [15:0] pending_next;
    logic        overflow_next;

    // Index of the lowest set bit; bit 0 has the highest priority.
    function automatic logic [3:0] pri(input logic [15:0] x);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (x[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    assign valid = (state == PRESENT);

    always_comb begin
        set           = en ? d : 16'h0000;
        clr           = (valid && ready) ? (16'h0001 << y) : 16'h0000;
        pending_next  = (pending & ~clr) | set;
        overflow_next = |(set & pending & ~clr);
    end

    always_comb begin
        state_next = state;
        y_next     = y;
        case (state)
            IDLE: begin
                if (pending_next != 16'h0000) begin
                    state_next = PRESENT;
                    y_next     = pri(pending_next);
                end
            end
            PRESENT: begin
                // Only an acceptance may move y, so late higher-priority
                // requests wait their turn instead of preempting.
                if (ready) begin
                    if (pending_next != 16'h0000) begin
                        y_next = pri(pending_next);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            y        <= 4'h0;
            pending  <= 16'h0000;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            y        <= y_next;
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_priority_encoder_16_4.sv
// Self-checking bench for priority_encoder_16_4: directed scenarios plus a
// randomized run against a set-based reference model.
module tb_priority_encoder_16_4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = 16'h0000;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] pending;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: the set of outstanding indices and the presented code.
    bit          m_pend [16];
    bit          m_valid;
    int          m_y;
    bit          m_ovf;

    priority_encoder_16_4 dut (
        .clk(clk), .rst(rst), .d(d), .en(en), .y(y), .valid(valid),
        .ready(ready), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int lowest_pending();
        for (int i = 0; i < 16; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [15:0] dd, input bit rd);
        bit accept;
        int nxt;
        if (r) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
            m_valid = 1'b0;
            m_y     = 0;
            m_ovf   = 1'b0;
            return;
        end
        accept = m_valid && rd;
        if (accept) m_pend[m_y] = 1'b0;
        m_ovf = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (e && dd[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (!m_valid || accept) begin
            nxt = lowest_pending();
            if (nxt >= 0) begin
                m_valid = 1'b1;
                m_y     = nxt;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit e, input logic [15:0] dd, input bit rd);
        rst   = r;
        en    = e;
        d     = dd;
        ready = rd;
        model_step(r, e, dd, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 1'b1, 16'hFFFF, 1'b1);
            n_checks++;
            if (valid !== 1'b0 || y !== 4'h0 || pending !== 16'h0000 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: valid=%b y=%h pending=%h ovf=%b, required 0/0/0000/0", valid, y, pending, overflow);
            end
        end
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, 1'b0, 16'h0000, 1'b0);
            n_checks++;
            if (valid !== 1'b0 || y !== 4'h0 || pending !== 16'h0000 || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_after: valid=%b y=%h pending=%h ovf=%b, required 0/0/0000/0", valid, y, pending, overflow);
            end
        end
    endtask

    task automatic test_stall();
        tick(1'b0, 1'b1, 16'h0400, 1'b0);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (valid !== 1'b1 || y !== 4'hA || pending !== 16'h0400) begin
                n_fail++;
                $display("FAIL stall_c%0d: valid=%b y=%h pending=%h, required 1/a/0400", c, valid, y, pending);
            end
            tick(1'b0, 1'b0, 16'h0000, 1'b0);
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%b pending=%h, required 0/0000", valid, pending);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_y [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
        tick(1'b0, 1'b1, 16'h8421, 1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (valid !== 1'b1 || y !== exp_y[k]) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%b y=%0d, required 1/%0d", k, valid, y, exp_y[k]);
            end
            tick(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        n_checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL drain_end: valid=%b pending=%h, required 0/0000", valid, pending);
        end
    endtask

    task automatic test_no_preempt();
        tick(1'b0, 1'b1, 16'h0100, 1'b0);
        tick(1'b0, 1'b1, 16'h0001, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || y !== 4'd8 || pending !== 16'h0101) begin
            n_fail++;
            $display("FAIL preempt_hold: valid=%b y=%0d pending=%h, required 1/8/0101", valid, y, pending);
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || y !== 4'd0 || pending !== 16'h0001) begin
            n_fail++;
            $display("FAIL preempt_next: valid=%b y=%0d pending=%h, required 1/0/0001", valid, y, pending);
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL preempt_end: valid=%b pending=%h, required 0/0000", valid, pending);
        end
    endtask

    task automatic test_collision();
        tick(1'b0, 1'b1, 16'h0008, 1'b0);
        tick(1'b0, 1'b1, 16'h0008, 1'b1);
        n_checks++;
        if (valid !== 1'b1 || y !== 4'd3 || pending !== 16'h0008 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_accept: valid=%b y=%0d pending=%h ovf=%b, required 1/3/0008/0", valid, y, pending, overflow);
        end
        tick(1'b0, 1'b1, 16'h0008, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || pending !== 16'h0008 || y !== 4'd3) begin
            n_fail++;
            $display("FAIL collide_ovf: ovf=%b pending=%h y=%0d, required 1/0008/3", overflow, pending, y);
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b0);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_pulse: ovf=%b, required 0", overflow);
        end
        tick(1'b0, 1'b0, 16'h0000, 1'b1);
    endtask

    task automatic test_enable_and_reset();
        tick(1'b0, 1'b0, 16'hFFFF, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || pending !== 16'h0000 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL en_gate: valid=%b pending=%h ovf=%b, required 0/0000/0", valid, pending, overflow);
        end
        tick(1'b0, 1'b1, 16'h00F0, 1'b0);
        n_checks++;
        if (valid !== 1'b1 || y !== 4'd4 || pending !== 16'h00F0) begin
            n_fail++;
            $display("FAIL load_f0: valid=%b y=%0d pending=%h, required 1/4/00f0", valid, y, pending);
        end
        tick(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (valid !== 1'b0 || pending !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_reset: valid=%b pending=%h, required 0/0000", valid, pending);
        end
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b0, 16'h0000, 1'b1);
            n_checks++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_quiet_%0d: valid=%b, required 0", c, valid);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] rd;
        bit          re, rr, rst_r;
        for (int c = 0; c < 400; c++) begin
            rd    = 16'($urandom);
            rd    = ($urandom_range(0, 1) == 0) ? (rd & 16'($urandom)) : rd;
            re    = ($urandom_range(0, 3) == 0);
            rr    = ($urandom_range(0, 2) != 0);
            rst_r = ($urandom_range(0, 99) == 0);
            tick(rst_r, re, rd, rr);
            n_checks++;
            if (valid !== m_valid || pending !== m_pend_vec() || overflow !== m_ovf ||
                (m_valid && y !== 4'(m_y))) begin
                n_fail++;
                $display("FAIL random_c%0d: valid=%b y=%0d pending=%h ovf=%b, required %b/%0d/%h/%b",
                         c, valid, y, pending, overflow, m_valid, m_y, m_pend_vec(), m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_back_to_back();
        test_no_preempt();
        test_collision();
        test_enable_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder_16_4.md
# priority_encoder_16_4

Registered 16-to-4 priority encoder with a sticky pending-request register and a valid/ready output handshake. It is the encoding counterpart of the 4-to-16 line decoder. Sixteen request lines are captured into a pending set. The index of the highest-priority pending line is presented as a 4-bit code, and each code is retired only when the consumer accepts it. The block sits between the scattered event sources and any consumer that needs one binary index at a time, such as a dispatcher or an interrupt handler.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- d  in  16  request lines; bit i high requests index i; several bits may be high.
- en  in  1  capture enable; d is ignored when en=0.
- y  out  4  encoded index being presented.
- valid  out  1  y holds a pending index.
- ready  in  1  consumer accepts y when valid & ready.
- pending  out  16  current pending set, registered.
- overflow  out  1  one-cycle pulse when a request merges into an already-pending, non-retiring bit.

## Operation
- Priority: lowest index wins; bit 0 is highest priority. pri(x) is the index of the lowest set bit of x.
- set = en ? d : 16'h0000.
- clr = (valid & ready) ? onehot(y) : 16'h0000.
- pending_next = (pending & ~clr) | set.
- If the same bit is cleared and set in one cycle, set wins and the bit stays pending.
- overflow_next = |(set & pending & ~clr).
- State machine, IDLE and PRESENT:
  - IDLE (valid=0): if pending_next != 0, go to PRESENT and load y = pri(pending_next). Otherwise stay in IDLE.
  - PRESENT (valid=1): if ready=0, y and valid stay frozen.
  - PRESENT with ready=1: if pending_next != 0, stay in PRESENT and load y = pri(pending_next), which gives back-to-back codes with no bubble. Otherwise go to IDLE.
- No preemption: a higher-priority request arriving while y is presented does not change y. It becomes eligible after the current acceptance.
- Arithmetic: pending is exactly 16 bits, so no counter or wrap is involved. All 16 bits pending with continuous ready=1 drains in 16 cycles, in index order 0..15.
- Reset:
  - rst=1 at an edge forces pending=16'h0000, state=IDLE, valid=0, y=4'h0, overflow=0.
  - Reset overrides same-cycle d/en and any in-flight handshake. That code is lost and is not retired to the consumer.

## Timing
- Every output is a register output. There is no combinational path from d, en or ready to any output.
- Capture latency: a request sampled at edge n is visible on pending, and (if the block was idle) on valid/y, immediately after edge n. That is 1 cycle from input to output.
- Acceptance is the edge where valid & ready = 1. After that edge the retired bit is gone from pending and the next code, if any, is on y.
- Throughput: one code per cycle while ready=1.
- ready may toggle freely. While valid=0, ready is ignored.
- y holds its last value while valid=0. Consumers must not sample y without valid.
- overflow is high for exactly the cycle after the merging edge.

## Test plan
- Reset: drive rst=1 with en=1, d=16'hFFFF for 2 cycles, then rst=0, d=0 -> valid=0, y=0, pending=16'h0000, overflow=0 throughout and afterwards.
- Single request, stall: en=1, d=16'h0400 for one cycle, ready=0 -> next cycle valid=1, y=4'hA, pending=16'h0400, all stable for 10 cycles. Then ready=1 for one cycle -> valid=0, pending=16'h0000.
- Drain order: d=16'h8421 for one cycle, ready held at 1 -> y=0,5,10,15 on 4 consecutive cycles with valid=1, then valid=0 and pending=0.
- No preemption: with y=8 presented and ready=0, inject d=16'h0001 -> y stays 8 and pending becomes 16'h0101. Accept -> next y=0, then y... pending=16'h0001, then after a second accept valid=0.
- Same-bit collision:
  - With y=3 presented, assert ready=1 and d=16'h0008 together -> bit 3 stays pending, y=3 is presented again next cycle, overflow=0.
  - Repeat with ready=0 -> a one-cycle overflow pulse and pending is unchanged.
- Enable gating and mid-op reset:
  - en=0 with d=16'hFFFF -> no change.
  - Load 16'h00F0, then assert rst while valid=1 and ready=1 -> the next cycle shows valid=0 and pending=0, and no further codes appear.
